// File: rtl/signal_decimator_pkg.sv
// Shared definitions for the boxcar decimator: FSM encoding, config width and
// the rate clamp that is also used by the register map.
package signal_decimator_pkg;

  localparam int LOG_RATE_WIDTH = 4;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Out-of-range requests saturate to the largest supported rate; this is not an error.
  function automatic logic [LOG_RATE_WIDTH-1:0] clamp_log_rate(
    input logic [LOG_RATE_WIDTH-1:0] log_rate,
    input int unsigned               max_log_rate
  );
    if (32'(log_rate) > max_log_rate) return LOG_RATE_WIDTH'(max_log_rate);
    return log_rate;
  endfunction

endpackage

// File: rtl/signal_decimator_axis_output_holder.sv
// Single-entry AXI-Stream output register. A result arriving while the entry is
// full and not being drained is discarded and recorded in a sticky overflow flag.
module axis_output_holder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  clear_ovf,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  overflow
);

  logic accept;
  logic drop;

  // A handshake in the same cycle frees the entry, so back-to-back results never drop.
  assign accept = load && (!tvalid || tready);
  assign drop   = load && tvalid && !tready;

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tdata    <= '0;
      tvalid   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        tdata  <= result;
        tvalid <= 1'b1;
      end else if (tvalid && tready) begin
        tvalid <= 1'b0;
      end

      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/signal_decimator.sv
// Boxcar-averaging decimator: each output is the floor-mean of 2^N consecutive
// valid input samples, N selectable at run time, delivered on an AXIS master.
module signal_decimator
  import signal_decimator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LOG_RATE     = 10,
  parameter int ACC_WIDTH        = AXIS_TDATA_WIDTH + MAX_LOG_RATE
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [LOG_RATE_WIDTH-1:0]   log_rate,
  input  logic                        clear_ovf,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        overflow
);

  localparam int CNT_WIDTH = MAX_LOG_RATE + 1;

  state_t                      state;
  logic [LOG_RATE_WIDTH-1:0]   eff_rate;
  logic [LOG_RATE_WIDTH-1:0]   rate_q;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sample_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0]        count;
  logic [CNT_WIDTH-1:0]        last_count;
  logic                        rate_change;
  logic                        block_done;
  logic [AXIS_TDATA_WIDTH-1:0] result;

  assign eff_rate    = clamp_log_rate(log_rate, MAX_LOG_RATE);
  assign sample_ext  = ACC_WIDTH'($signed(S_AXIS_tdata));
  assign acc_next    = acc + sample_ext;
  assign last_count  = (CNT_WIDTH'(1) << rate_q) - CNT_WIDTH'(1);
  assign rate_change = (state == ST_ACCUM) && (eff_rate != rate_q);
  assign block_done  = (state == ST_ACCUM) && !rate_change && S_AXIS_tvalid &&
                       (count == last_count);

  // Arithmetic shift gives the floor of the mean; the sum cannot exceed the accumulator.
  assign result = AXIS_TDATA_WIDTH'(acc_next >>> rate_q);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state  <= ST_ACCUM;
      rate_q <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (rate_change) begin
            // The partial block is meaningless at the new rate, so restart cleanly.
            state  <= ST_FLUSH;
            rate_q <= eff_rate;
            acc    <= '0;
            count  <= '0;
          end else if (S_AXIS_tvalid) begin
            if (block_done) begin
              acc   <= '0;
              count <= '0;
            end else begin
              acc   <= acc_next;
              count <= count + CNT_WIDTH'(1);
            end
          end
        end
        ST_FLUSH: state <= ST_ACCUM;
      endcase
    end
  end

  axis_output_holder #(
    .DATA_WIDTH(AXIS_TDATA_WIDTH)
  ) u_output_holder (
    .aclk      (aclk),
    .areset    (areset),
    .load      (block_done),
    .result    (result),
    .clear_ovf (clear_ovf),
    .tready    (M_AXIS_tready),
    .tdata     (M_AXIS_tdata),
    .tvalid    (M_AXIS_tvalid),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_signal_decimator.sv
// Self-checking bench for signal_decimator: directed vector table, hand-written
// corner sequences and randomized traffic against a block-averaging model.
module tb_signal_decimator;

  localparam int W = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    log_rate;
  logic          clear_ovf;
  logic [W-1:0]  s_tdata;
  logic          s_tvalid;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]   rate;
    logic         vld;
    logic [W-1:0] din;
    logic         exp_v;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  signal_decimator dut (
    .aclk          (aclk),
    .areset        (areset),
    .log_rate      (log_rate),
    .clear_ovf     (clear_ovf),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready),
    .overflow      (overflow)
  );

  always #4 aclk = ~aclk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of input, then sample outputs 1 time unit after the edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    s_tvalid = v;
    s_tdata  = d;
    @(posedge aclk);
    #1;
    clear_ovf = 1'b0;
  endtask

  task automatic set_rate(input logic [3:0] r);
    log_rate = r;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic v, input int d,
                              input logic ev, input int ed);
    vec_t t;
    t.rate = r; t.vld = v; t.din = d; t.exp_v = ev; t.exp_d = ed;
    return t;
  endfunction

  // Reference model state for randomized traffic.
  longint blk[$];
  logic         ev, eo;
  logic [W-1:0] ed;

  initial begin
    int early;
    logic [W-1:0] blk_val;
    areset = 1'b1; log_rate = 4'd0; clear_ovf = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;

    #13;
    check("reset tvalid", m_tvalid, 0);
    check("reset tdata", m_tdata, 0);
    check("reset overflow", overflow, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // N=0 pass-through, then N=2 floor averaging with input gaps.
    vecs.push_back(mk(0, 1, 5,  1, 5));
    vecs.push_back(mk(0, 1, -3, 1, -3));
    vecs.push_back(mk(0, 1, 7,  1, 7));
    vecs.push_back(mk(0, 0, 0,  0, 0));
    vecs.push_back(mk(2, 1, 1,  0, 0));
    vecs.push_back(mk(2, 1, 2,  0, 0));
    vecs.push_back(mk(2, 0, 99, 0, 0));
    vecs.push_back(mk(2, 1, 3,  0, 0));
    vecs.push_back(mk(2, 1, 6,  1, 3));
    vecs.push_back(mk(2, 1, -1, 0, 0));
    vecs.push_back(mk(2, 1, -1, 0, 0));
    vecs.push_back(mk(2, 0, 0,  0, 0));
    vecs.push_back(mk(2, 1, -1, 0, 0));
    vecs.push_back(mk(2, 1, -2, 1, -2));
    vecs.push_back(mk(2, 0, 0,  0, 0));
    foreach (vecs[i]) begin
      if (vecs[i].rate != log_rate) set_rate(vecs[i].rate);
      cycle(vecs[i].vld, vecs[i].din);
      check($sformatf("vec%0d tvalid", i), m_tvalid, vecs[i].exp_v);
      if (vecs[i].exp_v) check($sformatf("vec%0d tdata", i), m_tdata, vecs[i].exp_d);
      check($sformatf("vec%0d overflow", i), overflow, 0);
    end

    // Largest rate at full scale; second block requests 15, which clamps to 10.
    set_rate(4'd10);
    for (int b = 0; b < 2; b++) begin
      blk_val = (b == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      if (b == 1) log_rate = 4'd15;
      early = 0;
      for (int i = 0; i < 1024; i++) begin
        cycle(1'b1, blk_val);
        if (i < 1023 && m_tvalid) early++;
      end
      check($sformatf("n10 blk%0d early valid", b), early, 0);
      check($sformatf("n10 blk%0d tvalid", b), m_tvalid, 1);
      check($sformatf("n10 blk%0d tdata", b), m_tdata, blk_val);
    end
    cycle(1'b0, '0);

    // Backpressure: second result dropped, overflow sticky until cleared.
    m_tready = 1'b0;
    set_rate(4'd1);
    cycle(1'b1, 4); cycle(1'b1, 4);
    check("bp first tvalid", m_tvalid, 1);
    check("bp first tdata", m_tdata, 4);
    cycle(1'b1, 8); cycle(1'b1, 8);
    check("bp held tdata", m_tdata, 4);
    check("bp overflow set", overflow, 1);
    m_tready = 1'b1;
    cycle(1'b0, '0);
    check("bp consumed tvalid", m_tvalid, 0);
    check("bp overflow sticky", overflow, 1);
    clear_ovf = 1'b1;
    cycle(1'b0, '0);
    check("bp overflow cleared", overflow, 0);
    // Drop in the same cycle as clear: the drop wins.
    m_tready = 1'b0;
    cycle(1'b1, 1); cycle(1'b1, 1);
    cycle(1'b1, 2);
    clear_ovf = 1'b1;
    cycle(1'b1, 2);
    check("drop beats clear overflow", overflow, 1);
    check("drop beats clear tdata", m_tdata, 1);
    m_tready = 1'b1;
    cycle(1'b0, '0);
    clear_ovf = 1'b1;
    cycle(1'b0, '0);
    check("post-clear overflow", overflow, 0);

    // Rate change mid-block: partial block and FLUSH-cycle sample discarded.
    set_rate(4'd3);
    for (int i = 0; i < 5; i++) cycle(1'b1, 100);
    log_rate = 4'd1;
    cycle(1'b1, 999);
    check("rc change-cycle tvalid", m_tvalid, 0);
    cycle(1'b1, 555);
    check("rc flush-cycle tvalid", m_tvalid, 0);
    cycle(1'b1, 10);
    check("rc half block tvalid", m_tvalid, 0);
    cycle(1'b1, 20);
    check("rc result tvalid", m_tvalid, 1);
    check("rc result tdata", m_tdata, 15);
    cycle(1'b0, '0);

    // Asynchronous reset mid-block with a held output and overflow set.
    m_tready = 1'b0;
    set_rate(4'd2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8);
    for (int i = 0; i < 4; i++) cycle(1'b1, 9);
    cycle(1'b1, 3);
    #2;
    areset = 1'b1;
    #1;
    check("async reset tvalid", m_tvalid, 0);
    check("async reset tdata", m_tdata, 0);
    check("async reset overflow", overflow, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    m_tready = 1'b1;
    set_rate(4'd2);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4);
    check("post-reset tvalid", m_tvalid, 1);
    check("post-reset tdata", m_tdata, 4);

    // Randomized traffic with random backpressure against a block-mean model.
    for (int seg = 0; seg < 4; seg++) begin
      int unsigned n;
      n = $urandom_range(0, 3);
      m_tready = 1'b1;
      cycle(1'b0, '0);
      cycle(1'b0, '0);
      clear_ovf = 1'b1;
      cycle(1'b0, '0);
      set_rate(4'(n));
      blk.delete();
      ev = 1'b0; eo = 1'b0; ed = '0;
      for (int c = 0; c < 300; c++) begin
        logic v, r, got;
        logic [W-1:0] d;
        longint sum;
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 4) < 3);
        d = $urandom;
        got = 1'b0;
        sum = 0;
        if (v) begin
          blk.push_back(longint'($signed(d)));
          if (blk.size() == (1 << n)) begin
            foreach (blk[k]) sum += blk[k];
            sum = sum >>> n;
            got = 1'b1;
            blk.delete();
          end
        end
        if (got) begin
          if (!ev || r) begin ev = 1'b1; ed = sum[W-1:0]; end
          else eo = 1'b1;
        end else if (ev && r) begin
          ev = 1'b0;
        end
        m_tready = r;
        cycle(v, d);
        check($sformatf("rnd%0d.%0d tvalid", seg, c), m_tvalid, ev);
        if (ev) check($sformatf("rnd%0d.%0d tdata", seg, c), m_tdata, ed);
        check($sformatf("rnd%0d.%0d overflow", seg, c), overflow, eo);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/signal_decimator.md
Name: signal_decimator

Overview:
- Boxcar-averaging decimator directly downstream of the ADC channel splitter.
- Consumes one sign-extended channel stream at 125 MHz.
- Each output sample is the arithmetic mean of 2^N consecutive input samples, with N selected at run time.
- Output is an AXI-Stream master with backpressure, feeding the phase/velocity processing chain.

Parameters:
- AXIS_TDATA_WIDTH, 32: input/output tdata width; input is two's complement, sign-extended.
- MAX_LOG_RATE, 10: largest supported log2 decimation factor.
- ACC_WIDTH, AXIS_TDATA_WIDTH+MAX_LOG_RATE: accumulator width; guarantees no overflow.

Ports:
- aclk  input  1  sample clock, 125 MHz.
- areset  input  1  asynchronous, active-high reset.
- log_rate  input  4  requested log2 decimation factor N; quasi-static config register.
- clear_ovf  input  1  single-cycle pulse; clears the overflow flag.
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  signed input sample.
- S_AXIS_tvalid  input  1  sample qualifier; there is no tready, input is never stalled.
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  signed averaged sample.
- M_AXIS_tvalid  output  1  output valid.
- M_AXIS_tready  input  1  downstream ready.
- overflow  output  1  sticky flag: an output sample was dropped.

Behaviour:
- Reset (asynchronous, active-high): accumulator=0, count=0, M_AXIS_tdata=0, M_AXIS_tvalid=0, overflow=0, latched rate=0, state=ACCUM.
- Effective rate: N = min(log_rate, MAX_LOG_RATE).
- The latched rate register holds the effective N.
- States:
  - ACCUM: accumulating the current block.
  - FLUSH: one-cycle restart after a rate change.
- ACCUM, on each cycle with S_AXIS_tvalid=1:
  - acc_next = acc + sign_extend(tdata) to ACC_WIDTH.
  - If count == 2^N-1: result = acc_next >>> N (arithmetic shift, truncate toward -inf, low AXIS_TDATA_WIDTH bits); acc <= 0; count <= 0.
  - Otherwise: acc <= acc_next; count <= count+1.
- Cycles with tvalid=0 do not advance the block.
- N=0: pass-through with one-cycle registered latency.
- Latency: last sample of a block accepted in cycle k gives M_AXIS_tvalid=1 and the result in cycle k+1.
- Output register:
  - Holds tdata/tvalid stable until M_AXIS_tvalid & M_AXIS_tready.
  - tvalid deasserts the cycle after the handshake, unless a new result is loaded that same cycle.
- Simultaneous handshake and new result: the new result is loaded and tvalid stays 1. No drop, no overflow.
- Output full (tvalid=1, tready=0) when a new result is ready:
  - The new result is discarded and the held sample is kept.
  - overflow <= 1, sticky.
- clear_ovf=1 clears overflow; if a drop occurs in the same cycle, the drop wins (overflow stays 1).
- Rate change: effective log_rate differs from the latched rate in ACCUM:
  - Go to FLUSH: acc <= 0, count <= 0, latch the new rate; the partial block is discarded.
  - A sample arriving in the FLUSH cycle is ignored.
  - Return to ACCUM on the next cycle.
  - Any pending output sample is preserved.
- log_rate > MAX_LOG_RATE clamps to MAX_LOG_RATE; this is not an error.

Decomposition:
- Shared package holds:
  - Function clamp_log_rate(log_rate, MAX_LOG_RATE).
  - State encoding constants ST_ACCUM=0, ST_FLUSH=1.
  - Constant LOG_RATE_WIDTH=4, shared with the register map.
- Natural sub-module: axis_output_holder, the single-entry AXIS output register with load/drop/overflow logic.
- The accumulator, counter and FSM stay in the top module.

Test Plan:
- N=0, inputs 5,-3,7 on consecutive cycles, tready=1 -> outputs 5,-3,7 one cycle after each input; overflow=0.
- N=2, inputs 1,2,3,6 then -1,-1,-1,-2 -> outputs 3 then -2 (floor of -5/4), each the cycle after the 4th sample; tvalid gaps in the input stretch blocks correctly.
- N=10, 1024 samples of 0x7FFFFFFF -> output 0x7FFFFFFF (no accumulator overflow); 1024 samples of 0x80000000 -> 0x80000000.
- N=1, tready=0 held; inputs 4,4,8,8 -> tdata stays 4, second result dropped, overflow=1. Then tready=1 -> 4 consumed. Then clear_ovf pulse -> overflow=0.
- N=3, rate changed to 1 after 5 samples -> no output from the partial block, FLUSH-cycle sample ignored; next two samples 10,20 -> output 15.
- Assert areset mid-block with tvalid=1 pending -> all outputs 0 immediately (asynchronous). After release, N=2 block of 4,4,4,4 -> output 4.
